// File: rtl/amo_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : amo_mem_sequencer
// Description : Memory-side read-modify-write sequencer for RV64A AMO .D ops.
//               Reads the old doubleword, computes the new value, writes it
//               back and returns the old value with the request tag.
// Revision    : 1.0 - initial release
// ============================================================================
module amo_mem_sequencer #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [63:0]      req_addr_i,
  input  logic [63:0]      req_data_i,
  input  logic [3:0]       req_funct_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic             mem_req_we_o,
  output logic [63:0]      mem_req_addr_o,
  output logic [63:0]      mem_req_wdata_o,
  input  logic             mem_rsp_valid_i,
  input  logic [63:0]      mem_rsp_rdata_i,
  input  logic             mem_rsp_err_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [63:0]      resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             resp_err_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4,
    S_RESP    = 3'd5
  } state_e;

  localparam logic [3:0] c_funct_max = 4'd8;

  state_e           state_q, state_d;
  logic [63:0]      addr_q, addr_d;
  logic [63:0]      opnd_q, opnd_d;
  logic [3:0]       funct_q, funct_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [63:0]      old_q, old_d;
  logic [63:0]      new_q, new_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  // AMO ALU: ties keep the old value for min/max variants
  function automatic logic [63:0] amo_compute(input logic [3:0] f,
                                              input logic [63:0] old,
                                              input logic [63:0] rs2);
    logic [63:0] res;
    case (f)
      4'd0:    res = old + rs2;
      4'd1:    res = rs2;
      4'd2:    res = old ^ rs2;
      4'd3:    res = old & rs2;
      4'd4:    res = old | rs2;
      4'd5:    res = ($signed(rs2) < $signed(old)) ? rs2 : old;
      4'd6:    res = ($signed(rs2) > $signed(old)) ? rs2 : old;
      4'd7:    res = (rs2 < old) ? rs2 : old;
      4'd8:    res = (rs2 > old) ? rs2 : old;
      default: res = old;
    endcase
    return res;
  endfunction

  // State and datapath registers; reset drops any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      opnd_q  <= '0;
      funct_q <= '0;
      tag_q   <= '0;
      old_q   <= '0;
      new_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      opnd_q  <= opnd_d;
      funct_q <= funct_d;
      tag_q   <= tag_d;
      old_q   <= old_d;
      new_q   <= new_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state, datapath update and per-state handshake outputs
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    opnd_d          = opnd_q;
    funct_d         = funct_q;
    tag_d           = tag_q;
    old_d           = old_q;
    new_d           = new_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    req_ready_o     = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    resp_valid_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          opnd_d  = req_data_i;
          funct_d = req_funct_i;
          tag_d   = req_tag_i;
          // Misaligned or unknown op: answer with an error, touch no memory
          if ((req_addr_i[2:0] != 3'd0) || (req_funct_i > c_funct_max)) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_rsp_valid_i) begin
          old_d = mem_rsp_rdata_i;
          if (mem_rsp_err_i) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            // New value is registered so write data is steady in WR_REQ
            new_d   = amo_compute(funct_q, mem_rsp_rdata_i, opnd_q);
            state_d = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        if (mem_req_ready_i) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (mem_rsp_valid_i) begin
          rdata_d = old_q;
          err_d   = mem_rsp_err_i;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req_addr_o  = addr_q;
  assign mem_req_wdata_o = new_q;
  assign resp_data_o     = rdata_q;
  assign resp_tag_o      = tag_q;
  assign resp_err_o      = err_q;
  assign busy_o          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_amo_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_amo_mem_sequencer
// Description : Directed self-checking bench for amo_mem_sequencer with a
//               small behavioural memory that supports stalls and faults.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_amo_mem_sequencer;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [63:0]      req_addr_i = '0;
  logic [63:0]      req_data_i = '0;
  logic [3:0]       req_funct_i = '0;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic             mem_req_valid_o;
  logic             mem_req_ready_i = 1'b0;
  logic             mem_req_we_o;
  logic [63:0]      mem_req_addr_o;
  logic [63:0]      mem_req_wdata_o;
  logic             mem_rsp_valid_i = 1'b0;
  logic [63:0]      mem_rsp_rdata_i = '0;
  logic             mem_rsp_err_i = 1'b0;
  logic             resp_valid_o;
  logic             resp_ready_i = 1'b0;
  logic [63:0]      resp_data_o;
  logic [TAG_W-1:0] resp_tag_o;
  logic             resp_err_o;
  logic             busy_o;

  amo_mem_sequencer #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_funct_i(req_funct_i), .req_tag_i(req_tag_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_rdata_i(mem_rsp_rdata_i), .mem_rsp_err_i(mem_rsp_err_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_tag_o(resp_tag_o),
    .resp_err_o(resp_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model state
  logic [63:0] mem [logic [63:0]];
  int          rd_stall = 0, wr_stall = 0;
  bit          rd_err_inj = 0, wr_err_inj = 0;
  int          rd_count = 0, wr_count = 0;
  logic [63:0] last_wr_addr = '0, last_wr_data = '0;
  bit          hs_pending = 0;
  logic        hs_we = 1'b0;
  logic [63:0] hs_addr = '0, hs_wdata = '0;
  bit          ref_valid = 0, req_unstable = 0;
  logic        ref_we = 1'b0;
  logic [63:0] ref_addr = '0, ref_wdata = '0;

  // Memory model: decides ready and responses on the falling edge so the
  // DUT sees settled inputs at the next rising edge
  always @(negedge clk) begin
    mem_rsp_valid_i = 1'b0;
    mem_rsp_err_i   = 1'b0;
    mem_rsp_rdata_i = '0;
    mem_req_ready_i = 1'b0;
    if (!rst_n) begin
      hs_pending = 0;
      ref_valid  = 0;
    end else begin
      if (hs_pending) begin
        hs_pending      = 0;
        mem_rsp_valid_i = 1'b1;
        if (hs_we) begin
          mem[hs_addr]  = hs_wdata;
          last_wr_addr  = hs_addr;
          last_wr_data  = hs_wdata;
          mem_rsp_err_i = wr_err_inj;
        end else begin
          mem_rsp_rdata_i = mem.exists(hs_addr) ? mem[hs_addr] : 64'd0;
          mem_rsp_err_i   = rd_err_inj;
        end
      end
      if (mem_req_valid_o) begin
        if (ref_valid && (mem_req_addr_o !== ref_addr || mem_req_we_o !== ref_we ||
                          (mem_req_we_o && mem_req_wdata_o !== ref_wdata)))
          req_unstable = 1;
        ref_valid = 1;
        ref_addr  = mem_req_addr_o;
        ref_we    = mem_req_we_o;
        ref_wdata = mem_req_wdata_o;
        if (mem_req_we_o && wr_stall > 0) begin
          wr_stall--;
        end else if (!mem_req_we_o && rd_stall > 0) begin
          rd_stall--;
        end else begin
          mem_req_ready_i = 1'b1;
          hs_pending = 1;
          hs_we      = mem_req_we_o;
          hs_addr    = mem_req_addr_o;
          hs_wdata   = mem_req_wdata_o;
          ref_valid  = 0;
          if (mem_req_we_o) wr_count++;
          else rd_count++;
        end
      end
    end
  end

  // Issues one request, waits (bounded) for the response, holds resp_ready
  // low for 'hold' cycles, then completes the handshake
  task automatic run_req(input logic [63:0] a, input logic [63:0] d,
                         input logic [3:0] f, input logic [TAG_W-1:0] t,
                         input int hold, output int cyc,
                         output logic [63:0] rd, output logic [TAG_W-1:0] rt,
                         output logic re, output bit rdy_seen, output bit r_unst);
    @(negedge clk);
    req_addr_i = a; req_data_i = d; req_funct_i = f; req_tag_i = t;
    req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    cyc = 1;
    rdy_seen = 0;
    while (!resp_valid_o && cyc < 60) begin
      if (req_ready_o) rdy_seen = 1;
      @(negedge clk);
      cyc++;
    end
    rd = resp_data_o; rt = resp_tag_o; re = resp_err_o;
    r_unst = 0;
    for (int i = 0; i < hold; i++) begin
      if (req_ready_o) rdy_seen = 1;
      @(negedge clk);
      if (!resp_valid_o || resp_data_o !== rd || resp_tag_o !== rt || resp_err_o !== re)
        r_unst = 1;
    end
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
  endtask

  int               cyc;
  logic [63:0]      rd;
  logic [TAG_W-1:0] rt;
  logic             re;
  bit               rdy_seen, r_unst;

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready_o); end
    n_cmp++; if (mem_req_valid_o !== 1'b0 || resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_valids: memv=%b respv=%b busy=%b want 0", mem_req_valid_o, resp_valid_o, busy_o); end
    n_cmp++; if (mem_req_addr_o !== 64'd0 || resp_data_o !== 64'd0 || resp_err_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_data: addr=%h data=%h err=%b want 0", mem_req_addr_o, resp_data_o, resp_err_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    mem[64'h1000] = 64'd5;
    run_req(64'h1000, 64'd7, 4'd0, 4'h3, 0, cyc, rd, rt, re, rdy_seen, r_unst);
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL add_latency: got %0d want 5", cyc); end
    n_cmp++; if (rd !== 64'd5) begin n_bad++; $display("FAIL add_resp_data: got %h want 5", rd); end
    n_cmp++; if (rt !== 4'h3 || re !== 1'b0) begin n_bad++; $display("FAIL add_tag_err: tag=%h err=%b want 3/0", rt, re); end
    n_cmp++; if (mem[64'h1000] !== 64'd12 || last_wr_addr !== 64'h1000) begin
      n_bad++; $display("FAIL add_mem: mem=%h addr=%h want 12 @1000", mem[64'h1000], last_wr_addr); end
    n_cmp++; if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL add_back_idle: ready=%b busy=%b want 1/0", req_ready_o, busy_o); end
  endtask

  task automatic test_min_minu();
    mem[64'h2000] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_req(64'h2000, 64'd1, 4'd5, 4'h5, 0, cyc, rd, rt, re, rdy_seen, r_unst);
    n_cmp++; if (last_wr_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL min_wdata: got %h want ffffffffffffffff", last_wr_data); end
    n_cmp++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF || re !== 1'b0) begin n_bad++; $display("FAIL min_resp: data=%h err=%b want ffffffffffffffff/0", rd, re); end
    mem[64'h2000] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_req(64'h2000, 64'd1, 4'd7, 4'h6, 0, cyc, rd, rt, re, rdy_seen, r_unst);
    n_cmp++; if (last_wr_data !== 64'd1) begin n_bad++; $display("FAIL minu_wdata: got %h want 1", last_wr_data); end
    n_cmp++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF || rt !== 4'h6) begin n_bad++; $display("FAIL minu_resp: data=%h tag=%h want ffffffffffffffff/6", rd, rt); end
  endtask

  task automatic test_illegal();
    int r0, w0;
    r0 = rd_count; w0 = wr_count;
    run_req(64'h1004, 64'd1, 4'd0, 4'h9, 0, cyc, rd, rt, re, rdy_seen, r_unst);
    n_cmp++; if (re !== 1'b1 || rd !== 64'd0 || rt !== 4'h9) begin n_bad++; $display("FAIL misalign_resp: err=%b data=%h tag=%h want 1/0/9", re, rd, rt); end
    n_cmp++; if (cyc > 2) begin n_bad++; $display("FAIL misalign_latency: got %0d want <=2", cyc); end
    run_req(64'h1000, 64'd1, 4'd12, 4'hA, 0, cyc, rd, rt, re, rdy_seen, r_unst);
    n_cmp++; if (re !== 1'b1 || rd !== 64'd0) begin n_bad++; $display("FAIL funct12_resp: err=%b data=%h want 1/0", re, rd); end
    n_cmp++; if (cyc > 2) begin n_bad++; $display("FAIL funct12_latency: got %0d want <=2", cyc); end
    n_cmp++; if (rd_count !== r0 || wr_count !== w0) begin n_bad++; $display("FAIL illegal_no_mem: rd=%0d wr=%0d want %0d/%0d", rd_count, wr_count, r0, w0); end
  endtask

  task automatic test_faults();
    int r0, w0;
    mem[64'h3000] = 64'h55;
    r0 = rd_count; w0 = wr_count;
    rd_err_inj = 1;
    run_req(64'h3000, 64'd1, 4'd0, 4'h1, 0, cyc, rd, rt, re, rdy_seen, r_unst);
    rd_err_inj = 0;
    n_cmp++; if (re !== 1'b1 || rd !== 64'd0) begin n_bad++; $display("FAIL rdfault_resp: err=%b data=%h want 1/0", re, rd); end
    n_cmp++; if (rd_count !== r0 + 1 || wr_count !== w0 || mem[64'h3000] !== 64'h55) begin
      n_bad++; $display("FAIL rdfault_no_write: rd=%0d wr=%0d mem=%h want %0d/%0d/55", rd_count, wr_count, mem[64'h3000], r0 + 1, w0); end
    mem[64'h3008] = 64'h1234;
    wr_err_inj = 1;
    run_req(64'h3008, 64'hF0, 4'd4, 4'h2, 0, cyc, rd, rt, re, rdy_seen, r_unst);
    wr_err_inj = 0;
    n_cmp++; if (re !== 1'b1 || rd !== 64'h1234) begin n_bad++; $display("FAIL wrfault_resp: err=%b data=%h want 1/1234", re, rd); end
    n_cmp++; if (last_wr_data !== 64'h12F4) begin n_bad++; $display("FAIL wrfault_wdata: got %h want 12f4", last_wr_data); end
  endtask

  task automatic test_backpressure();
    int r0, w0;
    mem[64'h4000] = 64'h10;
    r0 = rd_count; w0 = wr_count;
    req_unstable = 0;
    rd_stall = 3; wr_stall = 3;
    run_req(64'h4000, 64'h20, 4'd8, 4'hC, 2, cyc, rd, rt, re, rdy_seen, r_unst);
    n_cmp++; if (rd_count !== r0 + 1 || wr_count !== w0 + 1) begin
      n_bad++; $display("FAIL bp_counts: rd=%0d wr=%0d want %0d/%0d", rd_count, wr_count, r0 + 1, w0 + 1); end
    n_cmp++; if (req_unstable !== 0 || r_unst !== 0) begin n_bad++; $display("FAIL bp_stable: mem_unstable=%0d resp_unstable=%0d want 0/0", req_unstable, r_unst); end
    n_cmp++; if (rdy_seen !== 0) begin n_bad++; $display("FAIL bp_req_ready: seen high=%0d want 0", rdy_seen); end
    n_cmp++; if (cyc !== 11) begin n_bad++; $display("FAIL bp_latency: got %0d want 11", cyc); end
    n_cmp++; if (last_wr_data !== 64'h20 || last_wr_addr !== 64'h4000 || rd !== 64'h10 || rt !== 4'hC) begin
      n_bad++; $display("FAIL bp_result: wdata=%h addr=%h data=%h tag=%h want 20/4000/10/c", last_wr_data, last_wr_addr, rd, rt); end
  endtask

  task automatic test_reset_midop();
    int w0, k;
    mem[64'h5000] = 64'h77;
    wr_stall = 100;
    w0 = wr_count;
    @(negedge clk);
    req_addr_i = 64'h5000; req_data_i = 64'h1; req_funct_i = 4'd0; req_tag_i = 4'h7;
    req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    k = 0;
    while (!(mem_req_valid_o && mem_req_we_o) && k < 40) begin @(negedge clk); k++; end
    n_cmp++; if (k >= 40) begin n_bad++; $display("FAIL midop_reach_wr: got timeout want WR_REQ"); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_req_valid_o !== 1'b0 || mem_req_we_o !== 1'b0 || resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL midop_ctrl_zero: memv=%b we=%b respv=%b busy=%b want 0", mem_req_valid_o, mem_req_we_o, resp_valid_o, busy_o); end
    n_cmp++; if (mem_req_addr_o !== 64'd0 || mem_req_wdata_o !== 64'd0 || resp_tag_o !== 4'h0) begin
      n_bad++; $display("FAIL midop_data_zero: addr=%h wdata=%h tag=%h want 0", mem_req_addr_o, mem_req_wdata_o, resp_tag_o); end
    wr_stall = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (req_ready_o !== 1'b1 || wr_count !== w0) begin n_bad++; $display("FAIL midop_release: ready=%b wr=%0d want 1/%0d", req_ready_o, wr_count, w0); end
    run_req(64'h5000, 64'hAA, 4'd1, 4'hE, 0, cyc, rd, rt, re, rdy_seen, r_unst);
    n_cmp++; if (rd !== 64'h77 || re !== 1'b0 || rt !== 4'hE || cyc !== 5) begin
      n_bad++; $display("FAIL midop_swap_resp: data=%h err=%b tag=%h cyc=%0d want 77/0/e/5", rd, re, rt, cyc); end
    n_cmp++; if (mem[64'h5000] !== 64'hAA) begin n_bad++; $display("FAIL midop_swap_mem: got %h want aa", mem[64'h5000]); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_min_minu();
    test_illegal();
    test_faults();
    test_backpressure();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
